// File: rtl/prio_enc_pkg.sv
// Shared constants for the registered dual priority encoder.
//   IN_W  : width of the request vector (bit IN_W-1 is highest priority)
//   IDX_W : width of an encoded index; 2**IDX_W must cover IN_W
package prio_enc_pkg;

  localparam int IN_W  = 12;
  localparam int IDX_W = 4;

endpackage

// File: rtl/prio_find_msb.sv
// Combinational find-most-significant-set-bit.
// Ports:
//   vec   : input vector to scan
//   idx   : index of the highest set bit (0 when vec is all zero)
//   found : 1 when vec has at least one set bit
module prio_find_msb #(
  parameter int IN_W  = 12,
  parameter int IDX_W = 4
) (
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan upward; each later set bit overrides earlier ones, so the
  // highest set bit is what remains.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered dual priority encoder: reports the top two set bits of the
// request vector, one cycle after sampling.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (clears all outputs)
//   in     : request vector, bit i set = requester i active
//   out    : index of highest set bit        valid  : in had >= 1 bit set
//   out2   : index of second-highest set bit valid2 : in had >= 2 bits set
module priority_encoder
  import prio_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic [IDX_W-1:0] out2,
  output logic             valid2
);

  logic [IDX_W-1:0] idx1, idx2;
  logic             found1, found2;
  logic [IN_W-1:0]  masked;

  logic [IDX_W-1:0] out_d, out_q, out2_d, out2_q;
  logic             valid_d, valid_q, valid2_d, valid2_q;

  prio_find_msb #(.IN_W(IN_W), .IDX_W(IDX_W)) u_find1 (
    .vec   (in),
    .idx   (idx1),
    .found (found1)
  );

  // Remove the first winner so the second search finds the runner-up.
  // With no bit set, idx1 is 0 and clearing bit 0 changes nothing.
  always_comb begin
    masked = in & ~(IN_W'(1) << idx1);
  end

  prio_find_msb #(.IN_W(IN_W), .IDX_W(IDX_W)) u_find2 (
    .vec   (masked),
    .idx   (idx2),
    .found (found2)
  );

  always_comb begin
    out_d    = idx1;
    valid_d  = found1;
    out2_d   = idx2;
    valid2_d = found2;
  end

  // All four results share one register stage so they stay coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      out2_q   <= '0;
      valid2_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      valid_q  <= valid_d;
      out2_q   <= out2_d;
      valid2_q <= valid2_d;
    end
  end

  assign out    = out_q;
  assign valid  = valid_q;
  assign out2   = out2_q;
  assign valid2 = valid2_q;

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;
  import prio_enc_pkg::*;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in;
  logic [IDX_W-1:0] out, out2;
  logic             valid, valid2;

  int n_cmp = 0;
  int n_err = 0;

  priority_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .valid  (valid),
    .out2   (out2),
    .valid2 (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int o, input int v, input int o2, input int v2);
    chk({tag, ".out"},    32'(out),    32'(o));
    chk({tag, ".valid"},  32'(valid),  32'(v));
    chk({tag, ".out2"},   32'(out2),   32'(o2));
    chk({tag, ".valid2"}, 32'(valid2), 32'(v2));
    chk({tag, ".range"},  32'(out <= 4'd11 && out2 <= 4'd11), 32'd1);
  endtask

  // Present a vector, take one edge, check the registered result.
  task automatic step(input logic [IN_W-1:0] v, input int o, input int vl,
                      input int o2, input int v2);
    in = v;
    @(posedge clk);
    #1;
    chk_all($sformatf("vec_%03h", v), o, vl, o2, v2);
  endtask

  initial begin
    rst = 1'b1;
    in  = 12'hFFF;
    #3;
    chk_all("reset_no_edge", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reset_held", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(12'hFFF, 11, 1, 10, 1);

    // single bits and empty
    step(12'h001, 0, 1, 0, 0);
    step(12'h002, 1, 1, 0, 0);
    step(12'h000, 0, 0, 0, 0);

    // ascending sweep
    step(12'h007, 2, 1, 1, 1);
    step(12'h00E, 3, 1, 2, 1);
    step(12'h01D, 4, 1, 3, 1);
    step(12'h03C, 5, 1, 4, 1);
    step(12'h07B, 6, 1, 5, 1);
    step(12'h0FA, 7, 1, 6, 1);
    step(12'h1F1, 8, 1, 7, 1);
    step(12'h3F4, 9, 1, 8, 1);
    step(12'h6E7, 10, 1, 9, 1);

    // gap below the MSB
    step(12'hBE6, 11, 1, 9, 1);
    step(12'h801, 11, 1, 0, 1);

    // back-to-back changes
    step(12'h001, 0, 1, 0, 0);
    step(12'h800, 11, 1, 0, 0);
    step(12'h000, 0, 0, 0, 0);
    step(12'hC00, 11, 1, 10, 1);

    // async reset between edges while outputs are valid
    in = 12'h0F0;
    #2 rst = 1'b1;
    #1;
    chk_all("midstream_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk_all("after_release_no_edge", 0, 0, 0, 0);
    step(12'h0F0, 7, 1, 6, 1);
    step(12'h411, 10, 1, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
